// File: rtl/bram_dma.sv
// bram_dma: single-channel copy/fill engine, initiator on one block-RAM port.
// Latency: first RAM access one cycle after start; copy 3 cycles/byte, fill 1 cycle/byte.
// Backpressure: read data is waited for in CAP until mem_dr, stalling indefinitely.
module bram_dma #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic [DATA_WIDTH-1:0] fill,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_do,
  input  logic                  mem_dr
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_q;    // current read address
  logic [ADDR_WIDTH-1:0] dst_q;    // current write address
  logic [ADDR_WIDTH-1:0] cnt_q;    // bytes still to write
  logic [DATA_WIDTH-1:0] fill_q;
  logic                  mode_q;   // 1 = fill

  // Control FSM; every RAM-side output is registered on the transition into the state that owns it.
  // mem_di doubles as the byte register: the captured read byte sits there until written out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      fill_q   <= '0;
      mode_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_di   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy   <= 1'b0;
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
          if (start && !abort) begin
            src_q  <= src;
            dst_q  <= dst;
            cnt_q  <= len;
            fill_q <= fill;
            mode_q <= mode;
            busy   <= 1'b1;
            if (len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (mode) begin
              state    <= WR;
              mem_cs   <= 1'b1;
              mem_we   <= 1'b1;
              mem_addr <= dst;
              mem_di   <= fill;
            end else begin
              state    <= RD;
              mem_cs   <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= src;
            end
          end
        end

        RD: begin
          state  <= CAP;
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
        end

        CAP: begin
          // Read data arrives with mem_dr; it goes straight into the write-data register.
          if (mem_dr) begin
            state    <= WR;
            mem_cs   <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= dst_q;
            mem_di   <= mem_do;
          end
        end

        WR: begin
          // Addresses wrap naturally at the top of the address space.
          src_q <= src_q + ONE;
          dst_q <= dst_q + ONE;
          cnt_q <= cnt_q - ONE;
          if (cnt_q == ONE) begin
            state  <= FIN;
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
            done   <= 1'b1;
          end else if (mode_q) begin
            state    <= WR;
            mem_cs   <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= dst_q + ONE;
            mem_di   <= fill_q;
          end else begin
            state    <= RD;
            mem_cs   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= src_q + ONE;
          end
        end

        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase

      // Abort overrides whatever the state logic chose; writes already issued stay in RAM.
      if (abort && state != IDLE) begin
        state  <= IDLE;
        busy   <= 1'b0;
        done   <= 1'b0;
        mem_cs <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bram_dma.sv
// Testbench for bram_dma: RAM model with optional read stall, byte-level reference memory,
// and per-scenario checks of contents, access order and cycle timing.
module tb_bram_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] src = '0;
  logic [15:0] dst = '0;
  logic [15:0] len = '0;
  logic [7:0]  fill = '0;
  logic        busy, done, mem_cs, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_di;
  logic [7:0]  mem_do = 8'h00;
  logic        mem_dr = 1'b1;

  int errors = 0;
  int checks = 0;

  bram_dma #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .src(src), .dst(dst), .len(len), .fill(fill),
    .busy(busy), .done(done), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do), .mem_dr(mem_dr)
  );

  always #5 clk = ~clk;

  // RAM model and reference image
  logic [7:0] ram     [0:65535];
  logic [7:0] exp_mem [0:65535];
  int stall_n = 0;
  int stall_cnt = 0;

  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_addr] <= mem_di;
    if (mem_cs && !mem_we) begin
      mem_do    <= ram[mem_addr];
      stall_cnt <= stall_n;
      mem_dr    <= (stall_n == 0);
    end else if (stall_cnt != 0) begin
      stall_cnt <= stall_cnt - 1;
      mem_dr    <= (stall_cnt == 1);
    end
  end

  // Cycle counter and bus monitor
  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) cyc++;

  logic [15:0] wr_q[$];
  logic [15:0] rd_q[$];
  int wr_cyc_q[$];
  int cs_cnt, done_cnt, done_cyc, busy_first, busy_last;

  always @(negedge clk) begin
    if (mem_cs && mem_we) begin
      wr_q.push_back(mem_addr);
      wr_cyc_q.push_back(cyc - t0);
    end
    if (mem_cs && !mem_we) rd_q.push_back(mem_addr);
    if (mem_cs) cs_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc - t0;
    end
    if (busy) begin
      if (busy_first < 0) busy_first = cyc - t0;
      busy_last = cyc - t0;
    end
  end

  task automatic clear_logs();
    wr_q.delete();
    rd_q.delete();
    wr_cyc_q.delete();
    cs_cnt = 0; done_cnt = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
  endtask

  // Reference: forward byte-sequential copy/fill with 16-bit wrap.
  task automatic model_op(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input int l, input logic [7:0] f);
    for (int i = 0; i < l; i++) begin
      logic [15:0] sa, da;
      sa = s + 16'(i);
      da = d + 16'(i);
      exp_mem[da] = m ? f : exp_mem[sa];
    end
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int a = 0; a < 65536; a++)
      if (ram[16'(a)] !== exp_mem[16'(a)]) n++;
    return n;
  endfunction

  task automatic do_start(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic [7:0] f);
    @(negedge clk);
    clear_logs();
    mode = m; src = s; dst = d; len = l; fill = f;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, mem_cs, mem_we, mem_addr, mem_di} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {busy, done, mem_cs, mem_we, mem_addr, mem_di});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_cs !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b cs=%b expected 0 0", busy, mem_cs);
    end
  endtask

  task automatic test_copy();
    bit to;
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      ram[16'h1000 + 16'(i)] = vals[i];
      exp_mem[16'h1000 + 16'(i)] = vals[i];
    end
    do_start(1'b0, 16'h1000, 16'h2000, 16'd4, 8'h00);
    wait_idle(to);
    model_op(1'b0, 16'h1000, 16'h2000, 4, 8'h00);
    checks++;
    if (to) begin errors++; $display("FAIL copy_timeout: engine still busy"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[16'h2000 + 16'(i)] !== vals[i]) begin
        errors++;
        $display("FAIL copy_byte%0d: got %h expected %h", i, ram[16'h2000 + 16'(i)], vals[i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 13) begin
      errors++;
      $display("FAIL copy_done: count=%0d cycle=%0d expected 1 at 13", done_cnt, done_cyc);
    end
    checks++;
    if (busy_first !== 1 || busy_last !== 13) begin
      errors++;
      $display("FAIL copy_busy: %0d..%0d expected 1..13", busy_first, busy_last);
    end
    checks++;
    if (cs_cnt !== 8) begin errors++; $display("FAIL copy_cs_cycles: got %0d expected 8", cs_cnt); end
  endtask

  task automatic test_fill();
    bit to;
    logic [7:0] keep;
    keep = ram[16'h3005];
    do_start(1'b1, 16'h0000, 16'h3000, 16'd5, 8'hA5);
    wait_idle(to);
    model_op(1'b1, 16'h0000, 16'h3000, 5, 8'hA5);
    checks++;
    if (to || wr_q.size() !== 5) begin
      errors++;
      $display("FAIL fill_writes: got %0d writes expected 5", wr_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wr_q[i] !== 16'h3000 + 16'(i) || wr_cyc_q[i] !== i + 1) begin
          errors++;
          $display("FAIL fill_wr%0d: addr %h cycle %0d expected %h cycle %0d",
                   i, wr_q[i], wr_cyc_q[i], 16'h3000 + 16'(i), i + 1);
        end
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 6) begin
      errors++;
      $display("FAIL fill_done: count=%0d cycle=%0d expected 1 at 6", done_cnt, done_cyc);
    end
    checks++;
    if (ram[16'h3005] !== keep) begin
      errors++;
      $display("FAIL fill_neighbour: got %h expected %h", ram[16'h3005], keep);
    end
    checks++;
    if (mem_diffs() !== 0) begin errors++; $display("FAIL fill_mem: %0d bytes differ, expected 0", mem_diffs()); end
  endtask

  task automatic test_wrap();
    bit to;
    logic [15:0] exp_rd [4];
    exp_rd[0] = 16'hFFFE; exp_rd[1] = 16'hFFFF; exp_rd[2] = 16'h0000; exp_rd[3] = 16'h0001;
    do_start(1'b0, 16'hFFFE, 16'h0010, 16'd4, 8'h00);
    wait_idle(to);
    model_op(1'b0, 16'hFFFE, 16'h0010, 4, 8'h00);
    checks++;
    if (to || rd_q.size() !== 4) begin
      errors++;
      $display("FAIL wrap_reads: got %0d reads expected 4", rd_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_q[i] !== exp_rd[i]) begin
          errors++;
          $display("FAIL wrap_rd%0d: got %h expected %h", i, rd_q[i], exp_rd[i]);
        end
      end
    end
    checks++;
    if (mem_diffs() !== 0) begin errors++; $display("FAIL wrap_mem: %0d bytes differ, expected 0", mem_diffs()); end
  endtask

  task automatic test_len_zero();
    bit to;
    do_start(1'b0, 16'h1234, 16'h4321, 16'd0, 8'h00);
    wait_idle(to);
    repeat (3) @(negedge clk);
    checks++;
    if (to || done_cnt !== 1 || done_cyc !== 1) begin
      errors++;
      $display("FAIL len0_done: count=%0d cycle=%0d expected 1 at 1", done_cnt, done_cyc);
    end
    checks++;
    if (busy_first !== 1 || busy_last !== 1 || cs_cnt !== 0) begin
      errors++;
      $display("FAIL len0_busy_cs: busy %0d..%0d cs=%0d expected 1..1 cs 0", busy_first, busy_last, cs_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    do_start(1'b0, 16'h5000, 16'h5800, 16'd8, 8'h00);
    repeat (5) @(negedge clk);
    mode = 1'b1; src = 16'h6000; dst = 16'h6800; len = 16'd3; fill = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(to);
    model_op(1'b0, 16'h5000, 16'h5800, 8, 8'h00);
    checks++;
    if (to || wr_q.size() !== 8 || done_cnt !== 1) begin
      errors++;
      $display("FAIL busy_start: writes=%0d done=%0d expected 8 and 1", wr_q.size(), done_cnt);
    end
    checks++;
    if (mem_diffs() !== 0) begin errors++; $display("FAIL busy_start_mem: %0d bytes differ, expected 0", mem_diffs()); end
  endtask

  task automatic test_stall();
    bit to;
    stall_n = 5;
    do_start(1'b0, 16'h4000, 16'h4800, 16'd3, 8'h00);
    wait_idle(to);
    stall_n = 0;
    model_op(1'b0, 16'h4000, 16'h4800, 3, 8'h00);
    checks++;
    if (to || done_cyc !== 25 || done_cnt !== 1) begin
      errors++;
      $display("FAIL stall_done: count=%0d cycle=%0d expected 1 at 25", done_cnt, done_cyc);
    end
    checks++;
    if (cs_cnt !== 6) begin errors++; $display("FAIL stall_cs_cycles: got %0d expected 6", cs_cnt); end
    checks++;
    if (mem_diffs() !== 0) begin errors++; $display("FAIL stall_mem: %0d bytes differ, expected 0", mem_diffs()); end
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    do_start(1'b0, 16'h7000, 16'h7100, 16'd6, 8'h00);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (wr_q.size() >= 2) begin seen = 1'b1; break; end
    end
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (!seen || busy !== 1'b0 || mem_cs !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: seen=%b busy=%b cs=%b expected 1 0 0", seen, busy, mem_cs);
    end
    abort = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    model_op(1'b0, 16'h7000, 16'h7100, 2, 8'h00);
    checks++;
    if (wr_q.size() !== 2 || done_cnt !== 0) begin
      errors++;
      $display("FAIL abort_writes: writes=%0d done=%0d expected 2 and 0", wr_q.size(), done_cnt);
    end
    checks++;
    if (mem_diffs() !== 0) begin errors++; $display("FAIL abort_mem: %0d bytes differ, expected 0", mem_diffs()); end
    // abort together with start in IDLE drops the request
    @(negedge clk);
    clear_logs();
    mode = 1'b1; dst = 16'h7200; len = 16'd4; fill = 8'h77;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (busy_first !== -1 || cs_cnt !== 0 || done_cnt !== 0) begin
      errors++;
      $display("FAIL abort_start: busy_first=%0d cs=%0d done=%0d expected -1 0 0", busy_first, cs_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_start(1'b1, 16'h0000, 16'h8000, 16'd20, 8'h5A);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_cs !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: busy=%b cs=%b we=%b expected 0 0 0", busy, mem_cs, mem_we);
    end
    model_op(1'b1, 16'h0000, 16'h8000, 4, 8'h5A);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_cs !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b done=%b cs=%b expected 0 0 0", busy, done, mem_cs);
    end
    checks++;
    if (mem_diffs() !== 0) begin errors++; $display("FAIL reset_mid_mem: %0d bytes differ, expected 0", mem_diffs()); end
    do_start(1'b0, 16'h8000, 16'h9000, 16'd6, 8'h00);
    wait_idle(to);
    model_op(1'b0, 16'h8000, 16'h9000, 6, 8'h00);
    checks++;
    if (to || done_cnt !== 1 || done_cyc !== 19 || mem_diffs() !== 0) begin
      errors++;
      $display("FAIL reset_mid_restart: done=%0d at %0d diffs=%0d expected 1 at 19 diffs 0",
               done_cnt, done_cyc, mem_diffs());
    end
  endtask

  task automatic test_random();
    bit to;
    for (int it = 0; it < 10; it++) begin
      logic m;
      logic [15:0] s, d;
      int l, exp_cyc, exp_cs;
      logic [7:0] f;
      m = 1'($urandom);
      s = 16'($urandom);
      d = (it == 0) ? s + 16'd1 : 16'($urandom);
      if (it == 0) m = 1'b0;
      l = $urandom_range(1, 24);
      f = 8'($urandom);
      do_start(m, s, d, 16'(l), f);
      wait_idle(to);
      model_op(m, s, d, l, f);
      exp_cyc = m ? l + 1 : 3 * l + 1;
      exp_cs  = m ? l : 2 * l;
      checks++;
      if (to || done_cnt !== 1 || done_cyc !== exp_cyc) begin
        errors++;
        $display("FAIL rand%0d_done: count=%0d cycle=%0d expected 1 at %0d", it, done_cnt, done_cyc, exp_cyc);
      end
      checks++;
      if (cs_cnt !== exp_cs) begin
        errors++;
        $display("FAIL rand%0d_cs: got %0d expected %0d", it, cs_cnt, exp_cs);
      end
      checks++;
      if (mem_diffs() !== 0) begin
        errors++;
        $display("FAIL rand%0d_mem: %0d bytes differ, expected 0", it, mem_diffs());
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      ram[16'(a)] = 8'($urandom);
      exp_mem[16'(a)] = ram[16'(a)];
    end
    clear_logs();
    test_reset();
    test_copy();
    test_fill();
    test_wrap();
    test_len_zero();
    test_start_while_busy();
    test_stall();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
